zybo_switches_axil_slave: RTL

AXI4-Lite slave (responder) for the Zybo switches IP; the bus initiator is the master VIP in the block-design bench. Provides four 32-bit RW scratch/control registers plus a debounced switch status register and a sticky change register. Sits between the PS AXI interconnect and the board slide switches.

---
 rtl/zybo_switches_axil_slave_if.sv | 37 +++
 rtl/zybo_switches_axil_slave.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/zybo_switches_axil_slave_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and the Zybo switches slave.
interface zybo_switches_axil_slave_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/zybo_switches_axil_slave.sv
// AXI4-Lite slave: 4 RW scratch regs, debounced switch status, sticky W1C change flags.
// Define ZYBO_SW_IRQ_EN to add the irq output and the RW irq mask at 0x1C.
module zybo_switches_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_SW             = 4,
    parameter int DEBOUNCE_CYCLES    = 16
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_areset,
    input  logic [NUM_SW-1:0] sw_in,
`ifdef ZYBO_SW_IRQ_EN
    output logic              irq,
`endif
    zybo_switches_axil_slave_if.slave s00_axi
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic              r_live;
    logic              r_aw_held, r_w_held, r_bvalid;
    logic [2:0]        r_awidx;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_regs [4];
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic [NUM_SW-1:0] r_sync1, r_sync2, r_status, r_change;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_aw_hs, w_w_hs, w_ar_hs, w_do_wr, w_accept;
    logic [2:0]        w_wr_idx;
    logic [31:0]       w_wr_data, w_bmask, w_wr_bits, w_rd_data;
    logic [3:0]        w_wr_strb;
    logic [NUM_SW-1:0] w_clr, w_set;
    logic              w_unused;

    // Readies stay low until the first edge after reset release.
    assign s00_axi.awready = r_live && !r_aw_held && !r_bvalid;
    assign s00_axi.wready  = r_live && !r_w_held && !r_bvalid;
    assign s00_axi.arready = r_live && !r_rvalid;
    assign s00_axi.bvalid  = r_bvalid;
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.rvalid  = r_rvalid;
    assign s00_axi.rdata   = r_rdata;
    assign s00_axi.rresp   = 2'b00;

    assign w_aw_hs = s00_axi.awvalid && s00_axi.awready;
    assign w_w_hs  = s00_axi.wvalid && s00_axi.wready;
    assign w_ar_hs = s00_axi.arvalid && s00_axi.arready;
    // A handshake this cycle counts as held, so simultaneous AW+W completes in one edge.
    assign w_do_wr   = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_idx  = r_aw_held ? r_awidx : s00_axi.awaddr[4:2];
    assign w_wr_data = r_w_held ? r_wdata : s00_axi.wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : s00_axi.wstrb;

    always_comb begin
        w_bmask = '0;
        for (int unsigned i = 0; i < 4; i++) w_bmask[i*8 +: 8] = {8{w_wr_strb[i]}};
    end

    assign w_wr_bits = w_wr_data & w_bmask;
    assign w_clr     = (w_do_wr && w_wr_idx == 3'd5) ? w_wr_bits[NUM_SW-1:0] : '0;
    assign w_accept  = (r_sync2 != r_status) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign w_set     = w_accept ? (r_sync2 ^ r_status) : '0;

    assign w_unused = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr, s00_axi.araddr};

`ifdef ZYBO_SW_IRQ_EN
    logic [NUM_SW-1:0] r_irq_mask;
    logic              r_irq;
    assign irq = r_irq;

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_do_wr && w_wr_idx == 3'd7)
                r_irq_mask <= (r_irq_mask & ~w_bmask[NUM_SW-1:0]) | w_wr_bits[NUM_SW-1:0];
            r_irq <= |(r_change & r_irq_mask);
        end
    end
`endif

    always_comb begin
        w_rd_data = '0;
        case (s00_axi.araddr[4:2])
            3'd0, 3'd1, 3'd2, 3'd3: w_rd_data = r_regs[s00_axi.araddr[3:2]];
            3'd4:    w_rd_data = 32'(r_status);
            3'd5:    w_rd_data = 32'(r_change);
            3'd6:    w_rd_data = {16'(DEBOUNCE_CYCLES), 8'(NUM_SW), 8'h01};
`ifdef ZYBO_SW_IRQ_EN
            3'd7:    w_rd_data = 32'(r_irq_mask);
`endif
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            for (int unsigned i = 0; i < 4; i++) r_regs[i] <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_do_wr) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                if (w_wr_idx < 3'd4)
                    r_regs[w_wr_idx[1:0]] <= (r_regs[w_wr_idx[1:0]] & ~w_bmask) | w_wr_bits;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awidx   <= s00_axi.awaddr[4:2];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s00_axi.wdata;
                    r_wstrb  <= s00_axi.wstrb;
                end
                if (r_bvalid && s00_axi.bready) r_bvalid <= 1'b0;
            end
            if (w_ar_hs) begin
                r_rdata  <= w_rd_data;
                r_rvalid <= 1'b1;
            end else if (r_rvalid && s00_axi.rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_status <= '0;
            r_change <= '0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_status) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_status <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_change <= (r_change & ~w_clr) | w_set;
        end
    end
endmodule
